hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage CPU.
- Produces the enable and clear controls for the IF/ID and ID/EX stage registers and the PC enable.
- Handles load-use hazards, EX-stage control-transfer flushes, and halt/resume.
- Keeps wrap-around statistics counters: cycles, stalls and flushes.

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller for the 5-stage CPU.
// Drives PC enable plus IF/ID and ID/EX enable/clear. Handles load-use stalls,
// EX-stage redirect flushes and halt/resume.
// Optional macro HAZ_STATS_EN: when defined, builds the cycle/stall/flush
// statistics counters. When undefined, the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             in_CLK,
  input  logic             in_CLR_N,
  input  logic [REG_W-1:0] in_id_rs,
  input  logic [REG_W-1:0] in_id_rt,
  input  logic             in_id_rs_used,
  input  logic             in_id_rt_used,
  input  logic             in_ex_memread,
  input  logic [REG_W-1:0] in_ex_rd,
  input  logic             in_ex_redirect,
  input  logic             in_ex_halt,
  input  logic             in_go,
  output logic             out_pc_en,
  output logic             out_ifid_en,
  output logic             out_ifid_clr,
  output logic             out_idex_clr,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cycle_cnt,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] out_flush_cnt
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t state, state_nxt;
  logic   lu;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // Register 0 is hardwired and never creates a dependency.
  assign lu = in_ex_memread && (in_ex_rd != '0) &&
              ((in_id_rs_used && (in_id_rs == in_ex_rd)) ||
               (in_id_rt_used && (in_id_rt == in_ex_rd)));

  // State register
  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) state <= S_RUN;
    else           state <= state_nxt;
  end

  // Next state and stage controls. Priority in RUN: halt > redirect > lu > normal.
  always_comb begin
    state_nxt    = state;
    out_pc_en    = 1'b0;
    out_ifid_en  = 1'b0;
    out_ifid_clr = 1'b0;
    out_idex_clr = 1'b0;
    out_halted   = 1'b0;
    if (!in_CLR_N) begin
      out_ifid_clr = 1'b1;
      out_idex_clr = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (in_ex_halt) begin
            out_idex_clr = 1'b1;
            state_nxt    = S_HALTED;
          end else if (in_ex_redirect) begin
            out_pc_en    = 1'b1;
            out_ifid_en  = 1'b1;
            out_ifid_clr = 1'b1;
            out_idex_clr = 1'b1;
          end else if (lu) begin
            out_idex_clr = 1'b1;
          end else begin
            out_pc_en    = 1'b1;
            out_ifid_en  = 1'b1;
          end
        end
        S_HALTED: begin
          out_halted   = 1'b1;
          out_idex_clr = 1'b1;
          if (in_go) state_nxt = S_RUN;
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  logic             run_cyc, flush_cyc, stall_cyc;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  assign run_cyc   = (state == S_RUN);
  assign flush_cyc = run_cyc && !in_ex_halt && in_ex_redirect;
  assign stall_cyc = run_cyc && !in_ex_halt && !in_ex_redirect && lu;

  // Wrapping statistics counters; frozen while HALTED
  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (run_cyc)   cycle_q <= cycle_q + 1'b1;
      if (stall_cyc) stall_q <= stall_q + 1'b1;
      if (flush_cyc) flush_q <= flush_q + 1'b1;
    end
  end

  assign out_cycle_cnt = cycle_q;
  assign out_stall_cnt = stall_q;
  assign out_flush_cnt = flush_q;
`else
  assign out_cycle_cnt = '0;
  assign out_stall_cnt = '0;
  assign out_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (CNT_W=4 so counter wrap is reachable).
// Stimulus pushes the expected output word; a monitor on the falling edge pops
// and compares it against the DUT.
module tb_hazard_ctrl;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             in_CLK = 1'b0;
  logic             in_CLR_N = 1'b0;
  logic [REG_W-1:0] in_id_rs = '0, in_id_rt = '0, in_ex_rd = '0;
  logic             in_id_rs_used = 1'b0, in_id_rt_used = 1'b0, in_ex_memread = 1'b0;
  logic             in_ex_redirect = 1'b0, in_ex_halt = 1'b0, in_go = 1'b0;
  logic             out_pc_en, out_ifid_en, out_ifid_clr, out_idex_clr, out_halted;
  logic [CNT_W-1:0] out_cycle_cnt, out_stall_cnt, out_flush_cnt;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .in_CLK(in_CLK), .in_CLR_N(in_CLR_N),
    .in_id_rs(in_id_rs), .in_id_rt(in_id_rt),
    .in_id_rs_used(in_id_rs_used), .in_id_rt_used(in_id_rt_used),
    .in_ex_memread(in_ex_memread), .in_ex_rd(in_ex_rd),
    .in_ex_redirect(in_ex_redirect), .in_ex_halt(in_ex_halt), .in_go(in_go),
    .out_pc_en(out_pc_en), .out_ifid_en(out_ifid_en), .out_ifid_clr(out_ifid_clr),
    .out_idex_clr(out_idex_clr), .out_halted(out_halted),
    .out_cycle_cnt(out_cycle_cnt), .out_stall_cnt(out_stall_cnt),
    .out_flush_cnt(out_flush_cnt)
  );

  always #5 in_CLK = ~in_CLK;

  // Expected word: {pc_en, ifid_en, ifid_clr, idex_clr, halted, cycle, stall, flush}
  typedef struct {
    string       name;
    logic [16:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;

  // Control patterns {pc_en, ifid_en, ifid_clr, idex_clr, halted}
  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_STAL = 5'b00010;
  localparam logic [4:0] C_FLSH = 5'b11110;
  localparam logic [4:0] C_HLT  = 5'b00011;

  // Monitor: one output word per vector, sampled mid-cycle
  always @(negedge in_CLK) begin
    if (sb.size() > 0) begin
      sb_t         e;
      logic [16:0] got;
      e   = sb.pop_front();
      got = {out_pc_en, out_ifid_en, out_ifid_clr, out_idex_clr, out_halted,
             out_cycle_cnt, out_stall_cnt, out_flush_cnt};
      n_vec++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b cyc=%0d stl=%0d fl=%0d, expected ctl=%b cyc=%0d stl=%0d fl=%0d",
                 e.name, got[16:12], got[11:8], got[7:4], got[3:0],
                 e.exp[16:12], e.exp[11:8], e.exp[7:4], e.exp[3:0]);
      end
    end
  end

  task automatic vec(input string nm, input logic rst_n,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic rsu, input logic rtu, input logic mr,
                     input logic [4:0] rd, input logic rdr, input logic hlt,
                     input logic g, input logic [4:0] ctl,
                     input int cyc, input int st, input int fl);
    sb_t         e;
    logic [3:0]  c4, s4, f4;
    @(posedge in_CLK);
    #1;
    in_CLR_N = rst_n; in_id_rs = rs; in_id_rt = rt;
    in_id_rs_used = rsu; in_id_rt_used = rtu; in_ex_memread = mr;
    in_ex_rd = rd; in_ex_redirect = rdr; in_ex_halt = hlt; in_go = g;
`ifdef HAZ_STATS_EN
    c4 = 4'(cyc); s4 = 4'(st); f4 = 4'(fl);
`else
    c4 = 4'd0; s4 = 4'd0; f4 = 4'd0;
`endif
    e.name = nm;
    e.exp  = {ctl, c4, s4, f4};
    sb.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [4:0] ctl,
                      input int cyc, input int st, input int fl);
    vec(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, cyc, st, fl);
  endtask

  task automatic do_reset(input string nm);
    vec(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST, 0, 0, 0);
  endtask

  initial begin
    // Reset state, then 10 idle RUN cycles
    do_reset("reset");
    for (int i = 0; i < 10; i++) idle("idle", C_NORM, i, 0, 0);
    // Load-use on rs: one bubble, then normal
    vec("lu_rs", 1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 0, C_STAL, 10, 0, 0);
    idle("after_lu", C_NORM, 11, 1, 0);
    // Register 0, unused operand and non-load never stall
    vec("lu_r0_rs", 1, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, C_NORM, 12, 1, 0);
    vec("lu_r0_rt", 1, 5'd8, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, C_NORM, 13, 1, 0);
    vec("rt_unused", 1, 5'd0, 5'd5, 0, 0, 1, 5'd5, 0, 0, 0, C_NORM, 14, 1, 0);
    vec("no_load", 1, 5'd7, 5'd0, 1, 0, 0, 5'd7, 0, 0, 0, C_NORM, 15, 1, 0);
    // Redirect beats load-use on rt
    vec("redir_lu", 1, 5'd0, 5'd9, 0, 1, 1, 5'd9, 1, 0, 0, C_FLSH, 16, 1, 0);
    idle("after_redir", C_NORM, 17, 1, 1);
    // Halt beats redirect; halt-entry cycle counts, halted cycles do not
    vec("halt_redir", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, C_STAL, 18, 1, 1);
    for (int i = 0; i < 4; i++) idle("halted", C_HLT, 19, 1, 1);
    vec("halted_ign", 1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 1, 1, 0, C_HLT, 19, 1, 1);
    vec("go", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, C_HLT, 19, 1, 1);
    idle("resumed", C_NORM, 19, 1, 1);
    vec("go_in_run", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, C_NORM, 20, 1, 1);
    idle("run_after_go", C_NORM, 21, 1, 1);
    // Reset mid-stall: immediate reset outputs, no remembered stall
    vec("lu_pre_rst", 1, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 0, 0, C_STAL, 22, 1, 1);
    vec("rst_mid_stall", 0, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 0, 0, C_RST, 0, 0, 0);
    idle("rel_stall", C_NORM, 0, 0, 0);
    idle("run1", C_NORM, 1, 0, 0);
    // Reset mid-halt
    vec("halt2", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, C_STAL, 2, 0, 0);
    idle("halted2", C_HLT, 3, 0, 0);
    do_reset("rst_mid_halt");
    idle("rel_halt", C_NORM, 0, 0, 0);
    // Wrap: 15 more RUN cycles reach 15, the next shows 0
    for (int i = 1; i <= 15; i++) idle("wrap_ramp", C_NORM, i, 0, 0);
    idle("wrap", C_NORM, 16, 0, 0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge in_CLK);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
